// File: rtl/uram_xfer_pkg.sv
// Shared definitions for the aclk->memclk URAM transfer: sample counts, phase
// index and the per-phase lane permutation.
package uram_xfer_pkg;

  localparam int unsigned NSAMP_MEM = 6;
  localparam int unsigned NSAMP_OUT = 8;
  localparam int unsigned LANE_SAMP = 2;
  localparam int unsigned NLANE     = NSAMP_MEM / LANE_SAMP;

  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;
  typedef logic [1:0] lane_idx_t;

  // Source lane in the stored word for output lane 'lane' at phase k.
  // The write side scrambles with the inverse of this mapping.
  function automatic lane_idx_t descramble(phase_t k, lane_idx_t lane);
    lane_idx_t src;
    src = lane;
    unique case (k)
      PH0: src = lane;
      PH1: src = (lane == 2'd0) ? 2'd1 : (lane == 2'd1) ? 2'd0 : lane;
      PH2: src = (lane == 2'd0) ? 2'd2 : (lane == 2'd2) ? 2'd0 : lane;
      PH3: src = (lane == 2'd0) ? 2'd1 : (lane == 2'd1) ? 2'd2 : 2'd0;
      default: src = lane;
    endcase
    return src;
  endfunction

endpackage

// File: rtl/uram_descramble.sv
// Combinational lane permutation undoing the write-side scramble for phase k_i.
module uram_descramble
  import uram_xfer_pkg::*;
#(
  parameter int    NBIT         = 12,
  parameter string SCRAMBLE_OPT = "TRUE"
) (
  input  logic [1:0]              k_i,
  input  logic [NSAMP_MEM*NBIT-1:0] din_i,
  output logic [NSAMP_MEM*NBIT-1:0] dout_o
);

  localparam int unsigned LW     = LANE_SAMP * NBIT;
  localparam bit          SCR_EN = (SCRAMBLE_OPT == "TRUE");

  always_comb begin
    dout_o = din_i;
    if (SCR_EN) begin
      for (int unsigned l = 0; l < NLANE; l++) begin
        dout_o[l*LW +: LW] =
          din_i[int'(descramble(phase_t'(k_i), lane_idx_t'(l)))*LW +: LW];
      end
    end
  end

endmodule

// File: rtl/uram_readout_unpack.sv
// Read-side unpacker: descrambles 6-sample URAM words and regroups every
// 4-word group into three 8-sample output words.
module uram_readout_unpack
  import uram_xfer_pkg::*;
#(
  parameter int    NBIT         = 12,
  parameter string SCRAMBLE_OPT = "TRUE"
) (
  input  logic                  memclk_i,
  input  logic                  memclk_rstn_i,
  input  logic [6*NBIT-1:0]     rd_dat_i,
  input  logic                  rd_valid_i,
  input  logic                  rd_first_i,
  output logic                  rd_ready_o,
  output logic [8*NBIT-1:0]     dout_o,
  output logic                  dout_valid_o,
  input  logic                  dout_ready_i,
  output logic                  align_err_o
);

  localparam int unsigned S = NBIT;
  localparam int unsigned W = NSAMP_MEM * NBIT;

  phase_t           k_q, k_d, k_eff;
  logic [W-1:0]     res_q, res_d, samp;
  logic [8*S-1:0]   dout_q, dout_d;
  logic             dv_q, dv_d, err_q, err_d;
  logic             acc;

  uram_descramble #(
    .NBIT         (NBIT),
    .SCRAMBLE_OPT (SCRAMBLE_OPT)
  ) u_descramble (
    .k_i    (k_eff),
    .din_i  (rd_dat_i),
    .dout_o (samp)
  );

  always_ff @(posedge memclk_i) begin
    if (!memclk_rstn_i) begin
      k_q    <= PH0;
      res_q  <= '0;
      dout_q <= '0;
      dv_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      k_q    <= k_d;
      res_q  <= res_d;
      dout_q <= dout_d;
      dv_q   <= dv_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    k_d = k_q;
    if (acc) begin
      unique case (k_eff)
        PH0: k_d = PH1;
        PH1: k_d = PH2;
        PH2: k_d = PH3;
        PH3: k_d = PH0;
        default: k_d = PH0;
      endcase
    end
  end

  // A first-flagged beat always restarts the group, dropping any residual;
  // the pending output word is left untouched.
  always_comb begin
    rd_ready_o = (k_q == PH0) || !dv_q || dout_ready_i;
    k_eff      = rd_first_i ? PH0 : k_q;
    acc        = rd_valid_i && rd_ready_o;
    res_d      = res_q;
    dout_d     = dout_q;
    dv_d       = dv_q && !dout_ready_i;
    err_d      = err_q;
    if (acc) begin
      if ((rd_first_i && k_q != PH0) || (!rd_first_i && k_q == PH0))
        err_d = 1'b1;
      unique case (k_eff)
        PH0: res_d = samp;
        PH1: begin
          dout_d           = {samp[2*S-1:0], res_q};
          res_d            = '0;
          res_d[4*S-1:0]   = samp[W-1:2*S];
          dv_d             = 1'b1;
        end
        PH2: begin
          dout_d           = {samp[4*S-1:0], res_q[4*S-1:0]};
          res_d            = '0;
          res_d[2*S-1:0]   = samp[W-1:4*S];
          dv_d             = 1'b1;
        end
        PH3: begin
          dout_d           = {samp, res_q[2*S-1:0]};
          res_d            = '0;
          dv_d             = 1'b1;
        end
        default: res_d = samp;
      endcase
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = dv_q;
  assign align_err_o  = err_q;

endmodule

// File: tb/tb_uram_readout_unpack.sv
// Directed bench for uram_readout_unpack (scrambled and pass-through instances).
module tb_uram_readout_unpack;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [71:0] rd_dat = '0;
  logic        rd_valid = 1'b0, rd_first = 1'b0, dout_ready = 1'b1;
  logic        rd_ready, dv, err, rd_ready_nf, dv_nf, err_nf;
  logic [95:0] dout, dout_nf;

  int tests = 0, fails = 0, timeouts = 0, stalls = 0, cyc = 0;
  logic [95:0] q_dat[$];
  int          q_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (rstn && dv && dout_ready) begin
      q_dat.push_back(dout);
      q_cyc.push_back(cyc);
    end

  uram_readout_unpack #(.NBIT(12), .SCRAMBLE_OPT("TRUE")) dut (
    .memclk_i(clk), .memclk_rstn_i(rstn), .rd_dat_i(rd_dat), .rd_valid_i(rd_valid),
    .rd_first_i(rd_first), .rd_ready_o(rd_ready), .dout_o(dout), .dout_valid_o(dv),
    .dout_ready_i(dout_ready), .align_err_o(err));

  uram_readout_unpack #(.NBIT(12), .SCRAMBLE_OPT("FALSE")) dut_nf (
    .memclk_i(clk), .memclk_rstn_i(rstn), .rd_dat_i(rd_dat), .rd_valid_i(rd_valid),
    .rd_first_i(rd_first), .rd_ready_o(rd_ready_nf), .dout_o(dout_nf), .dout_valid_o(dv_nf),
    .dout_ready_i(dout_ready), .align_err_o(err_nf));

  function automatic logic [71:0] ramp6(int b);
    logic [71:0] r;
    for (int j = 0; j < 6; j++) r[j*12 +: 12] = 12'(b + j);
    return r;
  endfunction

  function automatic logic [95:0] ramp8(int b);
    logic [95:0] r;
    for (int j = 0; j < 8; j++) r[j*12 +: 12] = 12'(b + j);
    return r;
  endfunction

  function automatic logic [95:0] pack8(int b, int o0, int o1, int o2, int o3,
                                        int o4, int o5, int o6, int o7);
    return {12'(b+o7), 12'(b+o6), 12'(b+o5), 12'(b+o4),
            12'(b+o3), 12'(b+o2), 12'(b+o1), 12'(b+o0)};
  endfunction

  // Write-side scramble: lane layout {lane2, lane1, lane0}.
  function automatic logic [71:0] scr(logic [71:0] d, int k);
    logic [23:0] l0, l1, l2;
    l0 = d[23:0]; l1 = d[47:24]; l2 = d[71:48];
    case (k)
      1:       return {l2, l0, l1};
      2:       return {l0, l1, l2};
      3:       return {l1, l0, l2};
      default: return d;
    endcase
  endfunction

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(logic [71:0] d, logic f);
    logic acc;
    rd_dat = d; rd_first = f; rd_valid = 1'b1;
    for (int n = 0; n <= 50; n++) begin
      if (n == 50) begin timeouts++; break; end
      @(negedge clk);
      acc = rd_ready;
      if (!acc) stalls++;
      @(posedge clk); #1;
      if (acc) break;
    end
    rd_valid = 1'b0; rd_first = 1'b0;
  endtask

  task automatic group(int b);
    for (int k = 0; k < 4; k++) beat(scr(ramp6(b + 6*k), k), k == 0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle(2);
    rstn = 1'b1;
    q_dat.delete(); q_cyc.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle(2);
    tests++; if (dout !== 96'h0) begin fails++; $display("FAIL reset_dout: got %h want 0", dout); end
    tests++; if (dv !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", dv); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
    tests++; if (rd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", rd_ready); end
    rstn = 1'b1;
    q_dat.delete(); q_cyc.delete();
    idle(1);
  endtask

  task automatic test_basic();
    dout_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      beat(scr(ramp6(6*k), k), k == 0);
      tests++;
      if (dv !== (k != 0)) begin fails++; $display("FAIL basic_valid k=%0d: got %b want %b", k, dv, k != 0); end
      if (k != 0) begin
        tests++;
        if (dout !== ramp8(8*(k-1))) begin
          fails++; $display("FAIL basic_dout k=%0d: got %h want %h", k, dout, ramp8(8*(k-1)));
        end
      end
    end
    idle(1);
    tests++; if (dv !== 1'b0) begin fails++; $display("FAIL basic_drain: got %b want 0", dv); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL basic_err: got %b want 0", err); end
    tests++; if (q_dat.size() !== 3) begin fails++; $display("FAIL basic_count: got %0d want 3", q_dat.size()); end
  endtask

  task automatic test_back_to_back();
    q_dat.delete(); q_cyc.delete(); stalls = 0;
    for (int g = 0; g < 4; g++) group(12'h100 + 24*g);
    idle(2);
    tests++; if (stalls !== 0) begin fails++; $display("FAIL b2b_ready: got %0d stalls want 0", stalls); end
    tests++; if (q_dat.size() !== 12) begin fails++; $display("FAIL b2b_count: got %0d want 12", q_dat.size()); end
    for (int i = 0; i < q_dat.size(); i++) begin
      tests++;
      if (q_dat[i] !== ramp8(12'h100 + 8*i)) begin
        fails++; $display("FAIL b2b_word%0d: got %h want %h", i, q_dat[i], ramp8(12'h100 + 8*i));
      end
      if (i > 0) begin
        tests++;
        if (q_cyc[i] - q_cyc[i-1] !== ((i % 3 == 0) ? 2 : 1)) begin
          fails++; $display("FAIL b2b_gap%0d: got %0d want %0d", i, q_cyc[i] - q_cyc[i-1], (i % 3 == 0) ? 2 : 1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int b = 12'h200;
    q_dat.delete(); q_cyc.delete();
    dout_ready = 1'b1;
    beat(scr(ramp6(b), 0), 1'b1);
    dout_ready = 1'b0;
    beat(scr(ramp6(b + 6), 1), 1'b0);
    rd_dat = scr(ramp6(b + 12), 2); rd_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tests++;
      if (rd_ready !== 1'b0) begin fails++; $display("FAIL bp_ready c=%0d: got %b want 0", c, rd_ready); end
      tests++;
      if (dv !== 1'b1 || dout !== ramp8(b)) begin
        fails++; $display("FAIL bp_hold c=%0d: got %b/%h want 1/%h", c, dv, dout, ramp8(b));
      end
      idle(1);
    end
    dout_ready = 1'b1;
    beat(scr(ramp6(b + 12), 2), 1'b0);
    beat(scr(ramp6(b + 18), 3), 1'b0);
    idle(2);
    tests++; if (q_dat.size() !== 3) begin fails++; $display("FAIL bp_count: got %0d want 3", q_dat.size()); end
    for (int i = 0; i < q_dat.size() && i < 3; i++) begin
      tests++;
      if (q_dat[i] !== ramp8(b + 8*i)) begin
        fails++; $display("FAIL bp_word%0d: got %h want %h", i, q_dat[i], ramp8(b + 8*i));
      end
    end
  endtask

  task automatic test_scramble_opt();
    int b = 12'h300;
    logic [95:0] exp_t;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      beat(ramp6(b + 6*k), k == 0);
      if (k != 0) begin
        case (k)
          1:       exp_t = pack8(b, 0, 1, 2, 3, 4, 5, 8, 9);
          2:       exp_t = pack8(b, 6, 7, 10, 11, 16, 17, 14, 15);
          default: exp_t = pack8(b, 12, 13, 20, 21, 22, 23, 18, 19);
        endcase
        tests++;
        if (dout_nf !== ramp8(b + 8*(k-1))) begin
          fails++; $display("FAIL nf_word k=%0d: got %h want %h", k, dout_nf, ramp8(b + 8*(k-1)));
        end
        tests++;
        if (dout !== exp_t) begin
          fails++; $display("FAIL scr_perm k=%0d: got %h want %h", k, dout, exp_t);
        end
      end
    end
    idle(1);
  endtask

  task automatic test_misalign();
    int a = 12'h400, b = 12'h500, c = 12'h600;
    do_reset();
    beat(scr(ramp6(a), 0), 1'b1);
    beat(scr(ramp6(a + 6), 1), 1'b0);
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL mis_err_pre: got %b want 0", err); end
    beat(scr(ramp6(b), 0), 1'b1);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL mis_err_set: got %b want 1", err); end
    tests++; if (dv !== 1'b0) begin fails++; $display("FAIL mis_no_out: got %b want 0", dv); end
    for (int k = 1; k < 4; k++) beat(scr(ramp6(b + 6*k), k), 1'b0);
    idle(2);
    tests++; if (q_dat.size() !== 4) begin fails++; $display("FAIL mis_count: got %0d want 4", q_dat.size()); end
    for (int i = 0; i < q_dat.size() && i < 4; i++) begin
      tests++;
      if (q_dat[i] !== ((i == 0) ? ramp8(a) : ramp8(b + 8*(i-1)))) begin
        fails++; $display("FAIL mis_word%0d: got %h", i, q_dat[i]);
      end
    end
    do_reset();
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL mis_err_clr: got %b want 0", err); end
    beat(scr(ramp6(c), 0), 1'b0);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL mis_nofirst: got %b want 1", err); end
    for (int k = 1; k < 4; k++) beat(scr(ramp6(c + 6*k), k), 1'b0);
    idle(2);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL mis_sticky: got %b want 1", err); end
    tests++; if (q_dat.size() !== 3) begin fails++; $display("FAIL mis_nf_count: got %0d want 3", q_dat.size()); end
    for (int i = 0; i < q_dat.size() && i < 3; i++) begin
      tests++;
      if (q_dat[i] !== ramp8(c + 8*i)) begin
        fails++; $display("FAIL mis_nf_word%0d: got %h want %h", i, q_dat[i], ramp8(c + 8*i));
      end
    end
  endtask

  task automatic test_reset_mid_group();
    int b = 12'h700, f = 12'h800;
    do_reset();
    beat(scr(ramp6(b), 0), 1'b0);
    beat(scr(ramp6(b + 6), 1), 1'b0);
    beat(scr(ramp6(b + 12), 2), 1'b0);
    tests++; if (dv !== 1'b1 || err !== 1'b1) begin fails++; $display("FAIL rmg_pre: got %b/%b want 1/1", dv, err); end
    rstn = 1'b0;
    idle(1);
    rstn = 1'b1;
    tests++; if (dv !== 1'b0) begin fails++; $display("FAIL rmg_valid: got %b want 0", dv); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL rmg_err: got %b want 0", err); end
    tests++; if (dout !== 96'h0) begin fails++; $display("FAIL rmg_dout: got %h want 0", dout); end
    q_dat.delete(); q_cyc.delete();
    group(f);
    idle(2);
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL rmg_err_after: got %b want 0", err); end
    tests++; if (q_dat.size() !== 3) begin fails++; $display("FAIL rmg_count: got %0d want 3", q_dat.size()); end
    for (int i = 0; i < q_dat.size() && i < 3; i++) begin
      tests++;
      if (q_dat[i] !== ramp8(f + 8*i)) begin
        fails++; $display("FAIL rmg_word%0d: got %h want %h", i, q_dat[i], ramp8(f + 8*i));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_scramble_opt();
    test_misalign();
    test_reset_mid_group();
    tests++; if (timeouts !== 0) begin fails++; $display("FAIL handshake_timeout: got %0d want 0", timeouts); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
